mem_arbiter: RTL and testbench

Shared-memory arbiter and sequencer between the instruction cache and the data cache. It accepts line-sized read and write requests from both caches, including same-cycle conflicts. It drives the single-port main memory with a fixed access latency and returns one-cycle completion pulses to the requester that was granted. It sits between the two cache controllers and `main_memory`, replacing per-cache ad-hoc memory access.

---
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache line requests onto single-port main memory; MEM_ARB_RR_EN selects round-robin, else dcache-priority.
// Latency: done pulse LATENCY cycles after the grant edge; one access per LATENCY+2 cycles.
// Backpressure: requests are held until done and ignored outside IDLE.
module mem_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int LINE_W  = 128,
  parameter int LATENCY = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              icache_req,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              dcache_req,
  input  logic              dcache_we,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [LINE_W-1:0] rdata,
  output logic              icache_done,
  output logic              dcache_done,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       wr_q;
  logic       last_grant;  // 1 = dcache, 0 = icache
  logic       grant_d;

  always_comb begin
    grant_d = dcache_req;
`ifdef MEM_ARB_RR_EN
    if (icache_req && dcache_req) begin
      grant_d = ~last_grant;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      wr_q        <= 1'b0;
      last_grant  <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata       <= '0;
      icache_done <= 1'b0;
      dcache_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (icache_req || dcache_req) begin
            state      <= BUSY;
            cnt        <= CNT_INIT;
            last_grant <= grant_d;
            wr_q       <= grant_d & dcache_we;
            mem_addr   <= grant_d ? dcache_addr : icache_addr;
            if (grant_d) begin
              mem_wdata <= dcache_wdata;
            end
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!wr_q) begin
              rdata <= mem_rdata;
            end
            if (last_grant) begin
              dcache_done <= 1'b1;
            end else begin
              icache_done <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          icache_done <= 1'b0;
          dcache_done <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write strobe aligns with the final BUSY cycle so memory commits on the done edge.
  assign mem_we = (state == BUSY) && (cnt == 4'd0) && wr_q;
  assign busy   = (state == BUSY) || (state == DONE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for single accesses plus conflict, reset-abort,
// back-to-back and LATENCY=1 sequences.
module tb_mem_arbiter;

  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_init;
  logic         icache_req, dcache_req, dcache_we;
  logic [19:0]  icache_addr, dcache_addr;
  logic [127:0] dcache_wdata;
  logic [19:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata, rdata;
  logic         mem_we, icache_done, dcache_done, busy;

  logic         l1_icache_req, l1_dcache_req, l1_dcache_we;
  logic [19:0]  l1_icache_addr, l1_dcache_addr;
  logic [127:0] l1_dcache_wdata;
  logic [19:0]  l1_mem_addr;
  logic [127:0] l1_mem_wdata, l1_rdata;
  logic         l1_mem_we, l1_icache_done, l1_dcache_done, l1_busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(20), .LINE_W(128), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .dcache_req(dcache_req), .dcache_we(dcache_we),
    .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .rdata(rdata),
    .icache_done(icache_done), .dcache_done(dcache_done), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(20), .LINE_W(128), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .icache_req(l1_icache_req), .icache_addr(l1_icache_addr),
    .dcache_req(l1_dcache_req), .dcache_we(l1_dcache_we),
    .dcache_addr(l1_dcache_addr), .dcache_wdata(l1_dcache_wdata),
    .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_we(l1_mem_we),
    .mem_rdata(128'h5A), .rdata(l1_rdata),
    .icache_done(l1_icache_done), .dcache_done(l1_dcache_done), .busy(l1_busy)
  );

  // Main memory model: 256 lines indexed by the low address byte.
  logic [127:0] mem [0:255];
  logic [255:0] vld;

  function automatic logic [127:0] preload(input logic [7:0] a);
    case (a)
      8'h10:   return {16{8'hA5}};
      8'h33:   return 128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C;
      default: return '0;
    endcase
  endfunction

  function automatic logic [127:0] mem_word(input logic [7:0] a);
    return vld[a] ? mem[a] : preload(a);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      vld <= '0;
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
      vld[mem_addr[7:0]] <= 1'b1;
    end
  end

  assign mem_rdata = mem_word(mem_addr[7:0]);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         i_req;
    logic [19:0]  i_addr;
    logic         d_req;
    logic         d_we;
    logic [19:0]  d_addr;
    logic [127:0] d_wdata;
    logic         exp_d;
    logic         exp_we;
    logic [127:0] exp_rdata;
  } vec_t;

  task automatic idle_inputs();
    icache_req = 0; dcache_req = 0; dcache_we = 0;
    icache_addr = '0; dcache_addr = '0; dcache_wdata = '0;
    l1_icache_req = 0; l1_dcache_req = 0; l1_dcache_we = 0;
    l1_icache_addr = '0; l1_dcache_addr = '0; l1_dcache_wdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1;
    @(posedge clk); @(posedge clk); #1 reset = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int done_n = -1, done_cnt = 0, other_cnt = 0, we_cnt = 0, we_n = -1, busy_hi = 0;
    logic [127:0] rd = '0;
    logic [19:0]  ma = '0;
    logic mine, other;
    @(posedge clk); #1;
    icache_req = v.i_req; icache_addr = v.i_addr;
    dcache_req = v.d_req; dcache_we = v.d_we; dcache_addr = v.d_addr; dcache_wdata = v.d_wdata;
    @(posedge clk); #1;
    icache_req = 0; dcache_req = 0;
    icache_addr = 20'hFFFFF; dcache_addr = 20'hFFFFF; dcache_wdata = '1;
    for (int n = 0; n <= LAT + 1; n++) begin
      @(negedge clk);
      if (n == 0) ma = mem_addr;
      mine  = v.exp_d ? dcache_done : icache_done;
      other = v.exp_d ? icache_done : dcache_done;
      if (mine) begin done_cnt++; done_n = n; rd = rdata; end
      if (other) other_cnt++;
      if (mem_we) begin we_cnt++; we_n = n; end
      if (busy) busy_hi++;
    end
    check($sformatf("v%0d done_cycle", idx), 128'(done_n), 128'(LAT));
    check($sformatf("v%0d done_pulses", idx), 128'(done_cnt), 128'd1);
    check($sformatf("v%0d wrong_done", idx), 128'(other_cnt), 128'd0);
    check($sformatf("v%0d we_count", idx), 128'(we_cnt), 128'(v.exp_we));
    if (v.exp_we) begin
      check($sformatf("v%0d we_cycle", idx), 128'(we_n), 128'(LAT - 1));
      check($sformatf("v%0d mem_content", idx), mem_word(v.d_addr[7:0]), v.d_wdata);
    end
    check($sformatf("v%0d mem_addr", idx), 128'(ma), 128'(v.exp_d ? v.d_addr : v.i_addr));
    check($sformatf("v%0d rdata", idx), rd, v.exp_rdata);
    check($sformatf("v%0d busy_cycles", idx), 128'(busy_hi), 128'(LAT + 1));
  endtask

  initial begin
    vec_t vecs[7];
    int   seq[3];
    int   got, both, rise[4], n_rise, low_cnt, we_seen, evt;
    logic prev_busy;

    vecs[0] = '{1'b1, 20'h00010, 1'b0, 1'b0, 20'h0,     128'h0,    1'b0, 1'b0, {16{8'hA5}}};
    vecs[1] = '{1'b0, 20'h0,     1'b1, 1'b1, 20'h00020, 128'h1234, 1'b1, 1'b1, {16{8'hA5}}};
    vecs[2] = '{1'b0, 20'h0,     1'b1, 1'b0, 20'h00020, 128'h0,    1'b1, 1'b0, 128'h1234};
    vecs[3] = '{1'b1, 20'h00033, 1'b0, 1'b0, 20'h0,     128'h0,    1'b0, 1'b0,
                128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C};
    vecs[4] = '{1'b0, 20'h0,     1'b1, 1'b1, 20'hFFF33, 128'hCAFE, 1'b1, 1'b1,
                128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C};
    vecs[5] = '{1'b1, 20'h00033, 1'b0, 1'b0, 20'h0,     128'h0,    1'b0, 1'b0, 128'hCAFE};
    vecs[6] = '{1'b0, 20'h0,     1'b1, 1'b0, 20'h00044, 128'h0,    1'b1, 1'b0, 128'h0};

    idle_inputs();
    reset = 1; mem_init = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0; mem_init = 0;

    @(negedge clk);
    check("rst mem_addr", 128'(mem_addr), 128'h0);
    check("rst mem_wdata", mem_wdata, 128'h0);
    check("rst rdata", rdata, 128'h0);
    check("rst mem_we", 128'(mem_we), 128'h0);
    check("rst icache_done", 128'(icache_done), 128'h0);
    check("rst dcache_done", 128'(dcache_done), 128'h0);
    check("rst busy", 128'(busy), 128'h0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Held conflict from a fresh reset
    do_reset();
    icache_req = 1; icache_addr = 20'h10; dcache_req = 1; dcache_we = 0; dcache_addr = 20'h20;
    got = 0; both = 0;
    for (int c = 0; c < 40 && got < 3; c++) begin
      @(negedge clk);
      if (icache_done && dcache_done) both++;
      if (icache_done || dcache_done) begin seq[got] = dcache_done ? 1 : 0; got++; end
    end
    @(posedge clk); #1 icache_req = 0; dcache_req = 0;
    check("conflict grants", 128'(got), 128'd3);
    check("conflict both_done", 128'(both), 128'd0);
`ifdef MEM_ARB_RR_EN
    check("conflict order0", 128'(seq[0]), 128'd1);
    check("conflict order1", 128'(seq[1]), 128'd0);
    check("conflict order2", 128'(seq[2]), 128'd1);
`else
    check("conflict order0", 128'(seq[0]), 128'd1);
    check("conflict order1", 128'(seq[1]), 128'd1);
    check("conflict order2", 128'(seq[2]), 128'd1);
`endif
    repeat (LAT + 3) @(posedge clk);

    // Reset two cycles into a write must abort it
    @(posedge clk); #1 dcache_req = 1; dcache_we = 1; dcache_addr = 20'h50; dcache_wdata = 128'hBEEF;
    @(posedge clk); #1 dcache_req = 0; dcache_we = 0;
    we_seen = 0;
    @(negedge clk); we_seen += int'(mem_we);
    @(negedge clk); we_seen += int'(mem_we);
    @(posedge clk); #1 reset = 1;
    @(negedge clk); we_seen += int'(mem_we);
    @(negedge clk);
    check("abort mem_we", 128'(we_seen + int'(mem_we)), 128'd0);
    check("abort busy", 128'(busy), 128'd0);
    check("abort dones", 128'({icache_done, dcache_done}), 128'd0);
    check("abort mem_addr", 128'(mem_addr), 128'h0);
    check("abort mem_wdata", mem_wdata, 128'h0);
    check("abort rdata", rdata, 128'h0);
    check("abort memory", mem_word(8'h50), 128'h0);
    @(posedge clk); #1 reset = 0;
    evt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      evt += int'(icache_done) + int'(dcache_done) + int'(mem_we) + int'(busy);
    end
    check("abort quiet", 128'(evt), 128'd0);

    // Back-to-back icache requests
    @(posedge clk); #1 icache_req = 1; icache_addr = 20'h10;
    n_rise = 0; low_cnt = 0; prev_busy = 1'b0;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      if (busy && !prev_busy && n_rise < 4) begin rise[n_rise] = k; n_rise++; end
      if (!busy && n_rise >= 1 && n_rise < 3) low_cnt++;
      prev_busy = busy;
    end
    #1 icache_req = 0;
    check("b2b grants", 128'(n_rise), 128'd3);
    if (n_rise >= 3) begin
      check("b2b gap1", 128'(rise[1] - rise[0]), 128'(LAT + 2));
      check("b2b gap2", 128'(rise[2] - rise[1]), 128'(LAT + 2));
    end
    check("b2b idle_cycles", 128'(low_cnt), 128'd2);
    repeat (LAT + 4) @(posedge clk);

    // LATENCY=1 instance: write then read
    @(posedge clk); #1 l1_dcache_req = 1; l1_dcache_we = 1; l1_dcache_addr = 20'h7; l1_dcache_wdata = 128'h99;
    @(posedge clk); #1 l1_dcache_req = 0; l1_dcache_we = 0;
    @(negedge clk);
    check("l1 we_n0", 128'({l1_mem_we, l1_busy, l1_dcache_done}), 128'b110);
    check("l1 wdata", l1_mem_wdata, 128'h99);
    check("l1 addr", 128'(l1_mem_addr), 128'h7);
    @(negedge clk);
    check("l1 done_n1", 128'({l1_mem_we, l1_busy, l1_dcache_done}), 128'b011);
    @(negedge clk);
    check("l1 idle_n2", 128'({l1_busy, l1_dcache_done}), 128'b00);
    @(posedge clk); #1 l1_icache_req = 1; l1_icache_addr = 20'h3;
    @(posedge clk); #1 l1_icache_req = 0;
    @(negedge clk);
    check("l1 rd_n0", 128'({l1_mem_we, l1_busy, l1_icache_done}), 128'b010);
    @(negedge clk);
    check("l1 rd_done", 128'({l1_icache_done, l1_dcache_done}), 128'b10);
    check("l1 rdata", l1_rdata, 128'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
